ps2_scancode_decoder: RTL

Consumes the byte stream produced by the PS/2 keyboard receiver stage and turns raw scan-code set-2 bytes into complete key events. It strips the E0 (extended), F0 (break) and E1 (pause) prefixes, tracks the Shift and Caps Lock state, and maps main-block keys to ASCII. Each event is queued in a small FIFO with a valid/ready handshake toward the system logic or display driver.

---
 rtl/ps2_scancode_decoder_if.sv | 26 ++
 rtl/ps2_scancode_decoder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_decoder_if.sv
// Byte-stream input and key-event output bundle for the PS/2 scan-code decoder.
interface ps2_scancode_decoder_if;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_extended;
    logic       evt_release;
    logic [7:0] evt_ascii;
    logic       shift_active;
    logic       caps_lock;
    logic       overflow;

    modport master (
        output byte_valid, byte_data, evt_ready,
        input  evt_valid, evt_code, evt_extended, evt_release, evt_ascii,
        input  shift_active, caps_lock, overflow
    );

    modport slave (
        input  byte_valid, byte_data, evt_ready,
        output evt_valid, evt_code, evt_extended, evt_release, evt_ascii,
        output shift_active, caps_lock, overflow
    );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// Strips E0/F0/E1 prefixes from set-2 scan bytes, tracks Shift/Caps Lock,
// maps main-block keys to ASCII and queues complete key events in a FIFO.
module ps2_scancode_decoder #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    ps2_scancode_decoder_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0, SKIP_E1} state_t;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
        logic [7:0] ascii;
    } evt_t;

    state_t     state_q, state_d;
    logic [2:0] skip_q, skip_d;
    logic       push, ext_c, rel_c;

    logic       lshift_q, lshift_d, rshift_q, rshift_d;
    logic       shift_q, caps_q, caps_d;
    logic       overflow_q;

    evt_t             mem_q [FIFO_DEPTH];
    evt_t             new_evt, head_q, head_d;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, pop, push_ok;

    // Lower-case ASCII for main-block keys; letters shift to upper case when asked
    function automatic logic [7:0] ascii_of(input logic [7:0] code, input logic upper);
        logic [7:0] a;
        logic       letter;
        a      = 8'h00;
        letter = 1'b1;
        case (code)
            8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
            8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
            8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
            8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
            8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
            8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
            8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
            default: letter = 1'b0;
        endcase
        if (!letter) begin
            case (code)
                8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
                8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
                8'h3E: a = 8'h38;  8'h46: a = 8'h39;
                8'h29: a = 8'h20;  8'h5A: a = 8'h0D;  8'h66: a = 8'h08;
                default: a = 8'h00;
            endcase
        end else if (upper) begin
            a = a - 8'h20;
        end
        return a;
    endfunction

    // Prefix FSM next-state and event generation
    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        push    = 1'b0;
        ext_c   = 1'b0;
        rel_c   = 1'b0;
        if (bus.byte_valid) begin
            if (state_q == SKIP_E1) begin
                skip_d = skip_q - 3'd1;
                if (skip_d == 3'd0) state_d = IDLE;
            end else begin
                case (bus.byte_data)
                    8'hE1: begin
                        state_d = SKIP_E1;
                        skip_d  = 3'd7;
                    end
                    8'hE0: state_d = GOT_E0;
                    8'hF0: begin
                        if (state_q == IDLE)        state_d = GOT_F0;
                        else if (state_q == GOT_E0) state_d = GOT_E0F0;
                    end
                    8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF: begin
                        if (state_q != IDLE) begin
                            push    = 1'b1;
                            ext_c   = (state_q == GOT_E0) || (state_q == GOT_E0F0);
                            rel_c   = (state_q == GOT_F0) || (state_q == GOT_E0F0);
                            state_d = IDLE;
                        end
                    end
                    default: begin
                        push    = 1'b1;
                        ext_c   = (state_q == GOT_E0) || (state_q == GOT_E0F0);
                        rel_c   = (state_q == GOT_F0) || (state_q == GOT_E0F0);
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    // Modifier tracking; extended codes never touch Shift or Caps Lock
    always_comb begin
        lshift_d = lshift_q;
        rshift_d = rshift_q;
        caps_d   = caps_q;
        if (push && !ext_c) begin
            case (bus.byte_data)
                8'h12: lshift_d = !rel_c;
                8'h59: rshift_d = !rel_c;
                8'h58: if (!rel_c) caps_d = !caps_q;
                default: ;
            endcase
        end
    end

    // FIFO control; the head register forwards a push landing in an emptied queue
    always_comb begin
        new_evt.ext   = ext_c;
        new_evt.rel   = rel_c;
        new_evt.code  = bus.byte_data;
        new_evt.ascii = (ext_c || rel_c) ? 8'h00 : ascii_of(bus.byte_data, shift_q ^ caps_q);
        pop      = valid_q && bus.evt_ready;
        push_ok  = push && ((count_q != CNT_W'(FIFO_DEPTH)) || pop);
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop);
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        head_d   = (push_ok && (wr_ptr_q == rd_ptr_d)) ? new_evt : mem_q[rd_ptr_d];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            skip_q     <= 3'd0;
            lshift_q   <= 1'b0;
            rshift_q   <= 1'b0;
            shift_q    <= 1'b0;
            caps_q     <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            head_q     <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            skip_q   <= skip_d;
            lshift_q <= lshift_d;
            rshift_q <= rshift_d;
            shift_q  <= lshift_d | rshift_d;
            caps_q   <= caps_d;
            if (push && !push_ok) overflow_q <= 1'b1;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= new_evt;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= (count_d != '0);
            head_q   <= head_d;
        end
    end

    assign bus.evt_valid    = valid_q;
    assign bus.evt_code     = head_q.code;
    assign bus.evt_extended = head_q.ext;
    assign bus.evt_release  = head_q.rel;
    assign bus.evt_ascii    = head_q.ascii;
    assign bus.shift_active = shift_q;
    assign bus.caps_lock    = caps_q;
    assign bus.overflow     = overflow_q;
endmodule
